// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared constants for the full-speed USB receive front end.
//   - line-state encodings as 2-bit {P,N}
//   - default deserializer width and minimum SE0 run for an EOP
//   - DPLL phase counter width and the phase at which the bit centre is sampled
package usb_rx_pkg;

    // Differential line states, encoded {P,N}
    typedef enum logic [1:0] {
        LINE_SE0 = 2'b00,
        LINE_K   = 2'b01,
        LINE_J   = 2'b10,
        LINE_SE1 = 2'b11
    } line_e;

    localparam int unsigned DEF_DATA_WIDTH  = 8;
    localparam int unsigned DEF_EOP_SE0_MIN = 4;

    // 4x oversampling: a 2-bit phase counter, bit centre at phase 2
    localparam int unsigned          PHASE_W      = 2;
    localparam logic [PHASE_W-1:0]   STROBE_PHASE = PHASE_W'(2);

endpackage

// File: rtl/usb_rx_dpll.sv
// usb_rx_dpll: pad synchronizer plus 4x oversampling digital PLL.
//   i_clk            48 MHz clock
//   i_rst            synchronous active-high reset
//   i_dp / i_dn      raw asynchronous pad inputs
//   o_sp / o_sn      synchronized line (2-flop), used by all downstream logic
//   o_strobe         one-cycle pulse at the bit centre (phase 2)
//   o_rxp / o_rxn    line sampled at the strobe, held until the next strobe
module usb_rx_dpll
    import usb_rx_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_dp,
    input  logic i_dn,
    output logic o_sp,
    output logic o_sn,
    output logic o_strobe,
    output logic o_rxp,
    output logic o_rxn
);

    logic               r_meta_p;
    logic               r_meta_n;
    logic               r_sync_p;
    logic               r_sync_n;
    logic               r_prev_p;
    logic [PHASE_W-1:0] r_phase;
    logic               r_strobe;
    logic               r_rxp;
    logic               r_rxn;

    logic               w_edge;
    logic [PHASE_W-1:0] w_phase_nxt;
    logic               w_at_centre;

    // Any P transition realigns; otherwise the phase free-runs and wraps 3->0.
    // The strobe is decoded from the next phase so it is high in the same
    // cycle the counter reads STROBE_PHASE (edge in E -> strobe in E+3).
    always_comb begin
        w_edge      = r_sync_p ^ r_prev_p;
        w_phase_nxt = w_edge ? '0 : r_phase + PHASE_W'(1);
        w_at_centre = (w_phase_nxt == STROBE_PHASE);
    end

    // Synchronizer resets to J so leaving reset never looks like an edge or SE0
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta_p <= 1'b1;
            r_meta_n <= 1'b0;
            r_sync_p <= 1'b1;
            r_sync_n <= 1'b0;
            r_prev_p <= 1'b1;
            r_phase  <= '0;
            r_strobe <= 1'b0;
            r_rxp    <= 1'b0;
            r_rxn    <= 1'b0;
        end else begin
            r_meta_p <= i_dp;
            r_meta_n <= i_dn;
            r_sync_p <= r_meta_p;
            r_sync_n <= r_meta_n;
            r_prev_p <= r_sync_p;
            r_phase  <= w_phase_nxt;
            r_strobe <= w_at_centre;
            if (w_at_centre) begin
                r_rxp <= r_sync_p;
                r_rxn <= r_sync_n;
            end
        end
    end

    assign o_sp     = r_sync_p;
    assign o_sn     = r_sync_n;
    assign o_strobe = r_strobe;
    assign o_rxp    = r_rxp;
    assign o_rxn    = r_rxn;

endmodule

// File: rtl/usb_rx_frontend.sv
// usb_rx_frontend: full-speed USB receive front end in the 48 MHz domain.
//   clk48, RST            clock and synchronous active-high reset
//   dataInP, dataInN      raw pad inputs (asynchronous)
//   eopReset              clears the sticky EOP flag and SE0 counter
//   shiftRegReset         clears the bit counter and full flag (data kept)
//   shiftIn, shiftEn      decoded bit and its qualifier (low for stuffed bits)
//   bitStrobe             one-cycle pulse at each bit centre
//   rxP, rxN              line sampled at the strobe
//   eop                   sticky end-of-packet flag
//   dataOut               deserializer contents, newest bit in the MSb
//   bufferFull            a full DATA_WIDTH-bit word has been collected
module usb_rx_frontend
    import usb_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned EOP_SE0_MIN = DEF_EOP_SE0_MIN
) (
    input  logic                  clk48,
    input  logic                  RST,
    input  logic                  dataInP,
    input  logic                  dataInN,
    input  logic                  eopReset,
    input  logic                  shiftRegReset,
    input  logic                  shiftIn,
    input  logic                  shiftEn,
    output logic                  bitStrobe,
    output logic                  rxP,
    output logic                  rxN,
    output logic                  eop,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  bufferFull
);

    localparam int unsigned SE0_CNT_W = $clog2(EOP_SE0_MIN + 1);
    localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH);

    localparam logic [SE0_CNT_W-1:0] SE0_CNT_MAX = '1;
    localparam logic [SE0_CNT_W-1:0] SE0_MIN_C   = SE0_CNT_W'(EOP_SE0_MIN);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST    = BIT_CNT_W'(DATA_WIDTH - 1);

    logic                  w_sp;
    logic                  w_sn;
    logic                  w_strobe;
    logic                  w_rxp;
    logic                  w_rxn;
    logic [1:0]            w_line;
    logic                  w_accept;

    logic [SE0_CNT_W-1:0]  r_se0_cnt;
    logic                  r_eop;
    logic [DATA_WIDTH-1:0] r_data;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic                  r_full;

    usb_rx_dpll u_dpll (
        .i_clk    (clk48),
        .i_rst    (RST),
        .i_dp     (dataInP),
        .i_dn     (dataInN),
        .o_sp     (w_sp),
        .o_sn     (w_sn),
        .o_strobe (w_strobe),
        .o_rxp    (w_rxp),
        .o_rxn    (w_rxn)
    );

    always_comb begin
        w_line   = {w_sp, w_sn};
        w_accept = w_strobe & shiftEn;
    end

    // EOP: count consecutive SE0 cycles (saturating); a J after a long enough
    // run sets the sticky flag, any other non-SE0 state just clears the run.
    always_ff @(posedge clk48) begin
        if (RST || eopReset) begin
            r_se0_cnt <= '0;
            r_eop     <= 1'b0;
        end else begin
            if (w_line == LINE_SE0) begin
                if (r_se0_cnt != SE0_CNT_MAX) begin
                    r_se0_cnt <= r_se0_cnt + SE0_CNT_W'(1);
                end
            end else begin
                r_se0_cnt <= '0;
            end
            if ((w_line == LINE_J) && (r_se0_cnt >= SE0_MIN_C)) begin
                r_eop <= 1'b1;
            end
        end
    end

    // Deserializer: shifting is never gated by the counter so the SIE can
    // hunt for sync in the upper bits; shiftRegReset drops a coincident bit.
    always_ff @(posedge clk48) begin
        if (RST) begin
            r_data    <= '0;
            r_bit_cnt <= '0;
            r_full    <= 1'b0;
        end else if (shiftRegReset) begin
            r_bit_cnt <= '0;
            r_full    <= 1'b0;
        end else if (w_accept) begin
            r_data <= {shiftIn, r_data[DATA_WIDTH-1:1]};
            if (r_bit_cnt == BIT_LAST) begin
                r_bit_cnt <= '0;
                r_full    <= 1'b1;
            end else begin
                r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                r_full    <= 1'b0;
            end
        end
    end

    assign bitStrobe  = w_strobe;
    assign rxP        = w_rxp;
    assign rxN        = w_rxn;
    assign eop        = r_eop;
    assign dataOut    = r_data;
    assign bufferFull = r_full;

endmodule

// File: tb/tb_usb_rx_frontend.sv
// tb_usb_rx_frontend: directed self-checking bench for usb_rx_frontend.
module tb_usb_rx_frontend;
    import usb_rx_pkg::*;

    logic       clk48 = 1'b0;
    logic       RST = 1'b1;
    logic       dataInP = 1'b0;
    logic       dataInN = 1'b0;
    logic       eopReset = 1'b0;
    logic       shiftRegReset = 1'b0;
    logic       shiftIn = 1'b0;
    logic       shiftEn = 1'b0;
    logic       bitStrobe;
    logic       rxP;
    logic       rxN;
    logic       eop;
    logic [7:0] dataOut;
    logic       bufferFull;

    usb_rx_frontend dut (
        .clk48         (clk48),
        .RST           (RST),
        .dataInP       (dataInP),
        .dataInN       (dataInN),
        .eopReset      (eopReset),
        .shiftRegReset (shiftRegReset),
        .shiftIn       (shiftIn),
        .shiftEn       (shiftEn),
        .bitStrobe     (bitStrobe),
        .rxP           (rxP),
        .rxN           (rxN),
        .eop           (eop),
        .dataOut       (dataOut),
        .bufferFull    (bufferFull)
    );

    always #5 clk48 = ~clk48;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   exp_next = 0;
    int   realign = 0;
    bit   chk_strobe = 1'b0;
    logic hp [1024];
    logic hn [1024];

    typedef struct {
        logic       shin;
        logic       en;
        logic       srr;
        logic [7:0] exp_data;
        logic       exp_full;
    } vec_t;

    vec_t vecs [25];

    task automatic check1(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Advance one cycle; sample 1 time unit after the edge. When enabled,
    // every cycle is checked against the expected strobe schedule: strobe at
    // synced-edge+3 (pad change +5), free-running every 4 cycles otherwise,
    // with rxP/rxN equal to the pad value three cycles earlier.
    task automatic tick();
        hp[cyc % 1024] = dataInP;
        hn[cyc % 1024] = dataInN;
        @(posedge clk48);
        #1;
        cyc++;
        if (chk_strobe) begin
            if (cyc == exp_next) begin
                check1("strobe_present", bitStrobe, 1'b1);
                check1("rxP_sample", rxP, hp[(cyc - 3) % 1024]);
                check1("rxN_sample", rxN, hn[(cyc - 3) % 1024]);
                exp_next = (realign > cyc) ? realign : cyc + 4;
            end else begin
                check1("strobe_absent", bitStrobe, 1'b0);
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // A P change retires any strobe not yet committed (>= 3 cycles away).
    task automatic drive_line(input logic [1:0] ln);
        if (ln[1] != dataInP) begin
            realign = cyc + 5;
            if (exp_next >= cyc + 3) exp_next = realign;
        end
        dataInP = ln[1];
        dataInN = ln[0];
    endtask

    // SE0 for n pad cycles, then J; optionally pulse eopReset in the J cycle.
    task automatic se0_then_j(input int n, input logic exp_eop, input logic rst_same);
        drive_line(LINE_SE0);
        ticks(n);
        drive_line(LINE_J);
        ticks(2);
        check1("eop_before_j", eop, 1'b0);
        if (rst_same) eopReset = 1'b1;
        tick();
        eopReset = 1'b0;
        check1("eop_after_j", eop, exp_eop);
    endtask

    task automatic clear_eop();
        eopReset = 1'b1;
        check1("eop_held_before_clear", eop, 1'b1);
        tick();
        eopReset = 1'b0;
        check1("eop_cleared", eop, 1'b0);
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        int n = 0;
        while (bitStrobe !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        if (bitStrobe !== 1'b1) begin
            check1("strobe_wait_timeout", bitStrobe, 1'b1);
        end else begin
            shiftIn       = v.shin;
            shiftEn       = v.en;
            shiftRegReset = v.srr;
            tick();
            shiftIn       = 1'b0;
            shiftEn       = 1'b0;
            shiftRegReset = 1'b0;
            check8($sformatf("dataOut_v%0d", idx), dataOut, v.exp_data);
            check1($sformatf("bufferFull_v%0d", idx), bufferFull, v.exp_full);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h80, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h40, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'hA0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'hA0, 1'b0};  // strobe without shiftEn
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'hD0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h68, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h34, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h9A, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h4D, 1'b1};  // 8th bit: byte complete
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'hA6, 1'b0};  // 9th bit clears full
        vecs[10] = '{1'b0, 1'b0, 1'b1, 8'hA6, 1'b0};  // counter cleared, data kept
        vecs[11] = '{1'b1, 1'b1, 1'b0, 8'hD3, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 8'hE9, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 8'hF4, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 8'hF4, 1'b0};  // bit dropped by reset
        vecs[15] = '{1'b0, 1'b1, 1'b0, 8'h7A, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 8'h3D, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 8'h1E, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 8'h0F, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 8'h07, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 1'b0, 8'h03, 1'b0};
        vecs[21] = '{1'b0, 1'b1, 1'b0, 8'h01, 1'b0};
        vecs[22] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1};  // 8 bits after the reset
        vecs[23] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1};  // full holds without bits
        vecs[24] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0};  // shiftRegReset clears full

        // Reset with the line at SE0 and junk on the other inputs
        RST = 1'b1;
        dataInP = 1'b0;
        dataInN = 1'b0;
        shiftIn = 1'b1;
        shiftEn = 1'b1;
        ticks(3);
        check1("rst_bitStrobe", bitStrobe, 1'b0);
        check1("rst_rxP", rxP, 1'b0);
        check1("rst_rxN", rxN, 1'b0);
        check1("rst_eop", eop, 1'b0);
        check8("rst_dataOut", dataOut, 8'h00);
        check1("rst_bufferFull", bufferFull, 1'b0);

        // Release at J; synchronizer was forced to J, so history is J
        RST = 1'b0;
        dataInP = 1'b1;
        dataInN = 1'b0;
        shiftIn = 1'b0;
        shiftEn = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            hp[i] = 1'b1;
            hn[i] = 1'b0;
        end
        chk_strobe = 1'b1;
        exp_next = cyc + 2;
        realign = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check1("post_rst_eop", eop, 1'b0);
        end
        check8("post_rst_dataOut", dataOut, 8'h00);

        // Clean lock: J/K toggles every 4 cycles
        for (int i = 0; i < 8; i++) begin
            drive_line((i % 2 == 0) ? LINE_K : LINE_J);
            ticks(4);
        end
        // Drift: one late edge, then lock again
        drive_line(LINE_K);
        ticks(5);
        for (int i = 0; i < 3; i++) begin
            drive_line((i % 2 == 0) ? LINE_J : LINE_K);
            ticks(4);
        end
        // Seven bit times with no edge: strobes must free-run
        drive_line(LINE_J);
        ticks(28);
        // Early edges at odd phases realign immediately
        drive_line(LINE_K);
        ticks(3);
        drive_line(LINE_J);
        ticks(2);
        drive_line(LINE_K);
        ticks(6);
        drive_line(LINE_J);
        ticks(8);

        // EOP detection
        check1("eop_idle", eop, 1'b0);
        se0_then_j(8, 1'b1, 1'b0);
        ticks(5);
        clear_eop();
        se0_then_j(2, 1'b0, 1'b0);
        ticks(4);
        se0_then_j(3, 1'b0, 1'b0);
        ticks(4);
        se0_then_j(4, 1'b1, 1'b0);
        ticks(3);
        clear_eop();
        se0_then_j(8, 1'b0, 1'b1);
        ticks(4);
        check1("eop_rst_priority_hold", eop, 1'b0);
        // SE0 interrupted by K: run discarded
        drive_line(LINE_SE0);
        ticks(6);
        drive_line(LINE_K);
        tick();
        drive_line(LINE_J);
        ticks(4);
        check1("eop_after_k", eop, 1'b0);
        ticks(4);

        // Deserializer vectors, line idle at J with free-running strobes
        for (int i = 0; i < 25; i++) begin
            apply_vec(vecs[i], i);
        end
        ticks(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
